// File: rtl/usbt_pkt_fifo_pkg.sv
// Shared definitions for the packet-aware receive FIFO: FSM states, entry field
// offsets (for the default 32-bit data / 6-bit endpoint layout) and entry sizing.
package usbt_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_DROP   = 2'd1,
    ST_HOLD   = 2'd2
  } fifo_state_e;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int COD_ENDP_WIDTH_DEF = 6;

  // Entry layout, LSB first: data, endp, entry_type, d_width[1:0], error, eop
  localparam int ENDP_LSB = DATA_WIDTH_DEF;
  localparam int TYPE_BIT = ENDP_LSB + COD_ENDP_WIDTH_DEF;
  localparam int DW_LSB   = TYPE_BIT + 1;
  localparam int ERR_BIT  = DW_LSB + 2;
  localparam int EOP_BIT  = ERR_BIT + 1;

  function automatic int entry_width(input int data_w, input int endp_w);
    return 5 + endp_w + data_w;
  endfunction

endpackage

// File: rtl/usbt_pkt_fifo_mem.sv
// DEPTH x WIDTH register array, one write port and one combinational read port.
// Kept as its own block so it can be swapped for a BIST-wrapped RAM.
module usbt_pkt_fifo_mem #(
  parameter int AWIDTH = 8,
  parameter int WIDTH  = 43
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is cleared on reset so read_data starts at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usbt_pkt_fifo.sv
// Packet-aware receive FIFO: entries are readable only after their packet's eop,
// overflowing packets are rolled back and dropped whole, writes resume after a
// free-space hysteresis. Optional debug taps under USBT_PKT_FIFO_MIC_EN.
module usbt_pkt_fifo
  import usbt_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int COD_ENDP_WIDTH = 6,
  parameter int AWIDTH         = 8,
  parameter int DROP_CNT_WIDTH = 8,
  parameter int ENTRY_WIDTH    = entry_width(DATA_WIDTH, COD_ENDP_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      write_command,
  input  logic [ENTRY_WIDTH-1:0]    write_data,
  output logic                      write_ready,
  input  logic [AWIDTH:0]           start_wr_again_th,
  input  logic                      read_command,
  output logic [ENTRY_WIDTH-1:0]    read_data,
  output logic                      read_ready,
  output logic [AWIDTH:0]           read_used,
  output logic [AWIDTH:0]           fifo_max_indication,
  input  logic                      fifo_max_indication_clr,
  output logic                      fifo_full,
  input  logic                      fifo_full_indication_clr,
  input  logic                      drop_cnt_clr,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`ifdef USBT_PKT_FIFO_MIC_EN
  ,
  output logic [31:0]               mic_fifo_0,
  output logic [31:0]               mic_fifo_1
`endif
);

  localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] DEPTH_V = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] PTR_ZERO = {(AWIDTH + 1){1'b0}};
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};

  fifo_state_e               state_q, state_d;
  logic [AWIDTH:0]           rd_ptr_q, rd_ptr_d, cm_ptr_q, cm_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0]           used_all_s, free_s;
  logic [AWIDTH:0]           read_used_q, read_used_d, max_q, max_d;
  logic                      read_ready_q, read_ready_d;
  logic                      in_pkt_q, in_pkt_d;
  logic                      full_q, full_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      wr_eop_s, mem_we_s, pop_s, drop_inc_s, full_set_s;

  assign wr_eop_s   = write_data[ENTRY_WIDTH-1];
  assign used_all_s = wr_ptr_q - rd_ptr_q;
  assign free_s     = DEPTH_V - used_all_s;
  assign pop_s      = read_command & read_ready_q;

  usbt_pkt_fifo_mem #(
    .AWIDTH (AWIDTH),
    .WIDTH  (ENTRY_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (mem_we_s),
    .waddr_i (wr_ptr_q[AWIDTH-1:0]),
    .wdata_i (write_data),
    .raddr_i (rd_ptr_q[AWIDTH-1:0]),
    .rdata_o (read_data)
  );

  // Write-side FSM: accept/commit, rollback on overflow, drop and hysteresis hold
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cm_ptr_d   = cm_ptr_q;
    mem_we_s   = 1'b0;
    drop_inc_s = 1'b0;
    full_set_s = 1'b0;
    if (write_command) in_pkt_d = ~wr_eop_s;
    else               in_pkt_d = in_pkt_q;
    case (state_q)
      ST_ACCEPT: begin
        if (write_command && (free_s != PTR_ZERO)) begin
          mem_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (wr_eop_s) cm_ptr_d = wr_ptr_q + PTR_ONE;
          else          cm_ptr_d = cm_ptr_q;
        end else if (write_command) begin
          wr_ptr_d   = cm_ptr_q;
          full_set_s = 1'b1;
          drop_inc_s = wr_eop_s;
          if (wr_eop_s) state_d = ST_HOLD;
          else          state_d = ST_DROP;
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_DROP: begin
        drop_inc_s = write_command & wr_eop_s;
        if (drop_inc_s) state_d = ST_HOLD;
        else            state_d = ST_DROP;
      end
      ST_HOLD: begin
        drop_inc_s = write_command & wr_eop_s;
        // in_pkt_d so a packet whose first word arrives this cycle still blocks resume
        if (!in_pkt_d && (free_s >= start_wr_again_th)) state_d = ST_ACCEPT;
        else                                            state_d = ST_HOLD;
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  // Read pointer and registered status
  always_comb begin
    if (pop_s) rd_ptr_d = rd_ptr_q + PTR_ONE;
    else       rd_ptr_d = rd_ptr_q;
    read_used_d  = cm_ptr_d - rd_ptr_d;
    read_ready_d = (cm_ptr_d != rd_ptr_d);
    if (fifo_max_indication_clr)  max_d = read_used_q;
    else if (read_used_q > max_q) max_d = read_used_q;
    else                          max_d = max_q;
    if (fifo_full_indication_clr) full_d = 1'b0;
    else if (full_set_s)          full_d = 1'b1;
    else                          full_d = full_q;
    if (drop_cnt_clr)                         drop_d = {DROP_CNT_WIDTH{1'b0}};
    else if (drop_inc_s && (drop_q != DROP_MAX)) drop_d = drop_q + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
    else                                      drop_d = drop_q;
  end

  // State, pointer and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ACCEPT;
      rd_ptr_q     <= PTR_ZERO;
      cm_ptr_q     <= PTR_ZERO;
      wr_ptr_q     <= PTR_ZERO;
      in_pkt_q     <= 1'b0;
      read_used_q  <= PTR_ZERO;
      read_ready_q <= 1'b0;
      max_q        <= PTR_ZERO;
      full_q       <= 1'b0;
      drop_q       <= {DROP_CNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      cm_ptr_q     <= cm_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      in_pkt_q     <= in_pkt_d;
      read_used_q  <= read_used_d;
      read_ready_q <= read_ready_d;
      max_q        <= max_d;
      full_q       <= full_d;
      drop_q       <= drop_d;
    end
  end

  assign write_ready         = (state_q == ST_ACCEPT);
  assign read_ready          = read_ready_q;
  assign read_used           = read_used_q;
  assign fifo_max_indication = max_q;
  assign fifo_full           = full_q;
  assign drop_cnt            = drop_q;

`ifdef USBT_PKT_FIFO_MIC_EN
  // Debug snapshot of both ports and pointers, sampled every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mic_fifo_0 <= 32'd0;
      mic_fifo_1 <= 32'd0;
    end else begin
      mic_fifo_0 <= {write_command, write_ready, state_q, 28'({wr_ptr_q, cm_ptr_q})};
      mic_fifo_1 <= {read_command, read_ready_q, 30'({rd_ptr_q, read_used_q})};
    end
  end
`endif

endmodule

// File: tb/tb_usbt_pkt_fifo.sv
// Self-checking bench for usbt_pkt_fifo (AWIDTH=3) against a queue-based packet model.
module tb_usbt_pkt_fifo;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int EW    = 43;
  localparam int DCW   = 8;
  localparam logic [EW-1:0] ZE = '0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          write_command;
  logic [EW-1:0] write_data;
  logic          write_ready;
  logic [AW:0]   start_wr_again_th;
  logic          read_command;
  logic [EW-1:0] read_data;
  logic          read_ready;
  logic [AW:0]   read_used;
  logic [AW:0]   fifo_max_indication;
  logic          fifo_max_indication_clr;
  logic          fifo_full;
  logic          fifo_full_indication_clr;
  logic          drop_cnt_clr;
  logic [DCW-1:0] drop_cnt;
`ifdef USBT_PKT_FIFO_MIC_EN
  logic [31:0]   mic_fifo_0, mic_fifo_1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: committed entries, current uncommitted packet, mode 0=accept 1=drop 2=hold
  logic [EW-1:0] m_com[$];
  logic [EW-1:0] m_pend[$];
  int            m_mode, m_drop, m_max;
  bit            m_inpkt, m_full;

  usbt_pkt_fifo #(.AWIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .write_command(write_command), .write_data(write_data), .write_ready(write_ready),
    .start_wr_again_th(start_wr_again_th),
    .read_command(read_command), .read_data(read_data), .read_ready(read_ready),
    .read_used(read_used),
    .fifo_max_indication(fifo_max_indication), .fifo_max_indication_clr(fifo_max_indication_clr),
    .fifo_full(fifo_full), .fifo_full_indication_clr(fifo_full_indication_clr),
    .drop_cnt_clr(drop_cnt_clr), .drop_cnt(drop_cnt)
`ifdef USBT_PKT_FIFO_MIC_EN
    , .mic_fifo_0(mic_fifo_0), .mic_fifo_1(mic_fifo_1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input bit eop);
    logic [EW-1:0] e;
    e[31:0]    = $urandom;
    e[EW-2:32] = 10'($urandom);
    e[EW-1]    = eop;
    return e;
  endfunction

  task automatic model_reset();
    m_com.delete(); m_pend.delete();
    m_mode = 0; m_drop = 0; m_max = 0; m_inpkt = 0; m_full = 0;
  endtask

  task automatic idle_inputs();
    write_command = 1'b0; write_data = ZE; read_command = 1'b0; start_wr_again_th = '0;
    fifo_max_indication_clr = 1'b0; fifo_full_indication_clr = 1'b0; drop_cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Apply one cycle of inputs, advance the model by the same cycle, return at posedge+1
  task automatic cycle(input logic wc, input logic [EW-1:0] wd, input logic rc,
                       input logic [AW:0] th, input logic mclr, input logic fclr, input logic dclr);
    int ru, freev, nm;
    bit pop, eop, inc, setf, inpkt_n;
    write_command = wc; write_data = wd; read_command = rc; start_wr_again_th = th;
    fifo_max_indication_clr = mclr; fifo_full_indication_clr = fclr; drop_cnt_clr = dclr;
    ru = m_com.size(); pop = rc && (ru > 0);
    freev = DEPTH - m_com.size() - m_pend.size();
    eop = wd[EW-1]; inc = 0; setf = 0; nm = m_mode;
    inpkt_n = wc ? !eop : m_inpkt;
    if (wc) begin
      if (m_mode == 0) begin
        if (freev > 0) begin
          m_pend.push_back(wd);
          if (eop) begin
            foreach (m_pend[i]) m_com.push_back(m_pend[i]);
            m_pend.delete();
          end
        end else begin
          m_pend.delete(); setf = 1;
          if (eop) begin inc = 1; nm = 2; end else nm = 1;
        end
      end else if (m_mode == 1) begin
        if (eop) begin inc = 1; nm = 2; end
      end else begin
        if (eop) inc = 1;
      end
    end
    if (m_mode == 2 && !inpkt_n && freev >= int'(th)) nm = 0;
    if (pop) void'(m_com.pop_front());
    m_max  = mclr ? ru : ((ru > m_max) ? ru : m_max);
    m_drop = dclr ? 0 : ((inc && m_drop < 255) ? m_drop + 1 : m_drop);
    m_full = fclr ? 0 : (setf ? 1 : m_full);
    m_mode = nm; m_inpkt = inpkt_n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (read_ready !== 1'b0) begin n_err++; $display("FAIL reset_read_ready got %0b want 0", read_ready); end
    n_cmp++; if (read_used !== 4'd0) begin n_err++; $display("FAIL reset_read_used got %0d want 0", read_used); end
    n_cmp++; if (read_data !== ZE) begin n_err++; $display("FAIL reset_read_data got %h want 0", read_data); end
    n_cmp++; if (write_ready !== 1'b1) begin n_err++; $display("FAIL reset_write_ready got %0b want 1", write_ready); end
    n_cmp++; if (fifo_max_indication !== 4'd0) begin n_err++; $display("FAIL reset_max got %0d want 0", fifo_max_indication); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", fifo_full); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_commit_latency();
    logic [EW-1:0] e[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      e[i] = mk(i == 2);
      cycle(1'b1, e[i], 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (read_ready !== (i == 2)) begin n_err++; $display("FAIL commit_ready after write %0d got %0b want %0b", i, read_ready, (i == 2)); end
    end
    n_cmp++; if (read_used !== 4'd3) begin n_err++; $display("FAIL commit_used got %0d want 3", read_used); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (read_data !== e[i]) begin n_err++; $display("FAIL commit_data[%0d] got %h want %h", i, read_data, e[i]); end
      cycle(1'b0, ZE, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    n_cmp++; if (read_ready !== 1'b0) begin n_err++; $display("FAIL commit_drained got %0b want 0", read_ready); end
  endtask

  task automatic test_overflow_hold();
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, mk(i == 6), 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(1'b0), 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(1'b1), 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %0b want 1", fifo_full); end
    n_cmp++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL ovf_drop got %0d want 1", drop_cnt); end
    n_cmp++; if (write_ready !== 1'b0) begin n_err++; $display("FAIL ovf_hold got %0b want 0", write_ready); end
    n_cmp++; if (read_used !== 4'd7) begin n_err++; $display("FAIL ovf_used got %0d want 7", read_used); end
    for (int i = 0; i < 3; i++) cycle(1'b0, ZE, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (write_ready !== 1'b0) begin n_err++; $display("FAIL hold_early got %0b want 0", write_ready); end
    cycle(1'b0, ZE, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (write_ready !== 1'b1) begin n_err++; $display("FAIL hold_exit got %0b want 1", write_ready); end
    // 4 free after rollback: a 4-entry packet must fit exactly
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(i == 3), 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (read_used !== 4'd8) begin n_err++; $display("FAIL rollback_used got %0d want 8", read_used); end
    cycle(1'b1, mk(1'b1), 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(1'b0), 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, ZE, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, ZE, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (write_ready !== 1'b0) begin n_err++; $display("FAIL inflight_hold got %0b want 0", write_ready); end
    cycle(1'b1, mk(1'b1), 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (write_ready !== 1'b1) begin n_err++; $display("FAIL inflight_exit got %0b want 1", write_ready); end
    n_cmp++; if (drop_cnt !== 8'd3) begin n_err++; $display("FAIL inflight_drop got %0d want 3", drop_cnt); end
    while (m_com.size() > 0) begin
      n_cmp++; if (read_data !== m_com[0]) begin n_err++; $display("FAIL rollback_data got %h want %h", read_data, m_com[0]); end
      cycle(1'b0, ZE, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_simul_rw_full();
    logic [EW-1:0] e[8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      e[i] = mk(i == 7);
      cycle(1'b1, e[i], 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    end
    n_cmp++; if (read_used !== 4'd8) begin n_err++; $display("FAIL full_used got %0d want 8", read_used); end
    cycle(1'b1, mk(1'b0), 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (read_used !== 4'd7) begin n_err++; $display("FAIL simul_used got %0d want 7", read_used); end
    n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL simul_full got %0b want 1", fifo_full); end
    n_cmp++; if (read_data !== e[1]) begin n_err++; $display("FAIL simul_data got %h want %h", read_data, e[1]); end
    n_cmp++; if (write_ready !== 1'b0) begin n_err++; $display("FAIL simul_drop_state got %0b want 0", write_ready); end
    cycle(1'b0, ZE, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL full_clr got %0b want 0", fifo_full); end
  endtask

  task automatic test_drop_counter();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, mk(i == 7), 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) cycle(1'b1, mk(1'b1), 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL drop_255 got %0d want 255", drop_cnt); end
    cycle(1'b1, mk(1'b1), 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL drop_sat got %0d want 255", drop_cnt); end
    cycle(1'b1, mk(1'b1), 1'b0, 4'd15, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL drop_clr_wins got %0d want 0", drop_cnt); end
    cycle(1'b1, mk(1'b1), 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL drop_after_clr got %0d want 1", drop_cnt); end
  endtask

  task automatic test_max_clear();
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, mk(i == 6), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, ZE, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (fifo_max_indication !== 4'd7) begin n_err++; $display("FAIL max_hwm got %0d want 7", fifo_max_indication); end
    cycle(1'b0, ZE, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, ZE, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (fifo_max_indication !== 4'd7) begin n_err++; $display("FAIL max_hold got %0d want 7", fifo_max_indication); end
    cycle(1'b0, ZE, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (fifo_max_indication !== 4'd5) begin n_err++; $display("FAIL max_clr got %0d want 5", fifo_max_indication); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(i == 3), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, mk(1'b0), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_cmp++; if (read_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready got %0b want 0", read_ready); end
    n_cmp++; if (read_used !== 4'd0) begin n_err++; $display("FAIL rstmid_used got %0d want 0", read_used); end
    n_cmp++; if (read_data !== ZE) begin n_err++; $display("FAIL rstmid_data got %h want 0", read_data); end
    n_cmp++; if (fifo_max_indication !== 4'd0) begin n_err++; $display("FAIL rstmid_max got %0d want 0", fifo_max_indication); end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(i == 2), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (read_used !== 4'd3) begin n_err++; $display("FAIL rstmid_new_used got %0d want 3", read_used); end
    n_cmp++; if (read_data !== m_com[0]) begin n_err++; $display("FAIL rstmid_new_data got %h want %h", read_data, m_com[0]); end
  endtask

  task automatic test_random();
    logic wc, rc, mc, fc, dc;
    logic [AW:0] th;
    int rd_pct;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rd_pct = ((c / 400) % 2 == 0) ? 25 : 80;
      wc = ($urandom % 100) < 60;
      rc = ($urandom % 100) < rd_pct;
      th = 4'($urandom_range(0, 9));
      mc = ($urandom % 40) == 0;
      fc = ($urandom % 40) == 0;
      dc = ($urandom % 60) == 0;
      cycle(wc, mk(($urandom % 4) == 0), rc, th, mc, fc, dc);
      n_cmp++; if (read_used !== 4'(m_com.size())) begin n_err++; $display("FAIL rnd_used c=%0d got %0d want %0d", c, read_used, m_com.size()); end
      n_cmp++; if (read_ready !== (m_com.size() > 0)) begin n_err++; $display("FAIL rnd_ready c=%0d got %0b", c, read_ready); end
      n_cmp++; if (write_ready !== (m_mode == 0)) begin n_err++; $display("FAIL rnd_wready c=%0d got %0b want %0b", c, write_ready, (m_mode == 0)); end
      n_cmp++; if (fifo_full !== m_full) begin n_err++; $display("FAIL rnd_full c=%0d got %0b want %0b", c, fifo_full, m_full); end
      n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_err++; $display("FAIL rnd_drop c=%0d got %0d want %0d", c, drop_cnt, m_drop); end
      n_cmp++; if (fifo_max_indication !== 4'(m_max)) begin n_err++; $display("FAIL rnd_max c=%0d got %0d want %0d", c, fifo_max_indication, m_max); end
      if (m_com.size() > 0) begin
        n_cmp++; if (read_data !== m_com[0]) begin n_err++; $display("FAIL rnd_data c=%0d got %h want %h", c, read_data, m_com[0]); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_commit_latency();
    test_overflow_hold();
    test_simul_rw_full();
    test_drop_counter();
    test_max_clear();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usbt_pkt_fifo.md
# usbt_pkt_fifo

Packet-aware, parametrised receive FIFO placed between the HDBT/USB parser write port and the CPU read port of the main parse path. It replaces a plain word FIFO. Entries become visible to the reader only once their packet's EOP entry is written. A packet that overflows is rolled back and dropped whole, and writing resumes only after a free-space hysteresis threshold is met.

## Interface
Parameters:
- DATA_WIDTH, 32, payload bits per entry
- COD_ENDP_WIDTH, 6, coded endpoint field width
- AWIDTH, 8, address bits; DEPTH = 2**AWIDTH entries
- DROP_CNT_WIDTH, 8, width of saturating drop counter
- ENTRY_WIDTH, 5+COD_ENDP_WIDTH+DATA_WIDTH, derived: {eop, error, d_width[1:0], entry_type, endp, data}

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- write_command  in  1  write one entry this cycle
- write_data  in  ENTRY_WIDTH  entry; bit ENTRY_WIDTH-1 is eop
- write_ready  out  1  1 = ACCEPT state (informational; writes are never stalled)
- start_wr_again_th  in  AWIDTH+1  free entries required to leave HOLD
- read_command  in  1  pop head entry
- read_data  out  ENTRY_WIDTH  head entry (first-word-fall-through)
- read_ready  out  1  committed entry available
- read_used  out  AWIDTH+1  committed entries
- fifo_max_indication  out  AWIDTH+1  high-water mark of read_used
- fifo_max_indication_clr  in  1  clear high-water mark
- fifo_full  out  1  sticky overflow flag
- fifo_full_indication_clr  in  1  clear fifo_full
- drop_cnt  out  DROP_CNT_WIDTH  dropped packets, saturating
- drop_cnt_clr  in  1  clear drop_cnt

## Operation
- Pointers rd_ptr, cm_ptr (committed), wr_ptr are AWIDTH+1 bits and wrap naturally. used_all = wr_ptr-rd_ptr; read_used = cm_ptr-rd_ptr; free = DEPTH-used_all.
- FSM states: ACCEPT, DROP, HOLD; reset state is ACCEPT.
- ACCEPT, write_command with free>0: store at wr_ptr, wr_ptr+1. If eop, cm_ptr is set to the new wr_ptr.
- ACCEPT, write_command with free==0: wr_ptr is set to cm_ptr (rollback) and fifo_full is set. If the entry has eop, drop_cnt+1 and the next state is HOLD; otherwise the next state is DROP.
- DROP: discard all writes. On an eop write, drop_cnt+1 and the next state is HOLD.
- HOLD: discard writes. A packet arriving in HOLD counts one drop at its eop. Go to ACCEPT when no packet is in flight (in_pkt==0) and free >= start_wr_again_th. in_pkt is set by a non-eop write and cleared by an eop write.
- Read: read_command && read_ready pops head (rd_ptr+1). read_command with read_ready==0 is ignored, with no pointer change.
- Simultaneous read and write: both execute. free for the write is evaluated before the pop.
- fifo_max_indication loads read_used when read_used exceeds it. When clr is asserted, it loads the current read_used, and clr wins over the update.
- drop_cnt saturates at all-ones. Clear wins over increment.
- fifo_full clear wins over set in the same cycle.

## Timing
- Reset values: pointers 0, read_ready 0, read_used 0, read_data 0 (storage reset), write_ready 1, fifo_max_indication 0, fifo_full 0, drop_cnt 0.
- Commit latency: entries become readable the cycle after the eop write; read_ready rises one cycle after that write.
- read_data is combinational from storage at rd_ptr, valid whenever read_ready=1.
- Status outputs are registered and update one cycle after the causing event.
- Reset asserted mid-packet discards the partial and committed data and returns the FSM to ACCEPT.

## Configuration
- USBT_PKT_FIFO_MIC_EN defined: adds outputs mic_fifo_0/mic_fifo_1 (32 bits each), registered every cycle:
  - mic_fifo_0 = {write_command, write_ready, state[1:0], 28'(wr_ptr,cm_ptr)}
  - mic_fifo_1 = {read_command, read_ready, 30'(rd_ptr, read_used)}
- Not defined: these ports and registers are absent; functional behaviour is identical.

## Structure
- Shared package usbt_pkg holds:
  - the FSM state enum (ACCEPT/DROP/HOLD)
  - entry field offset constants (EOP_BIT, ERR_BIT, DW_LSB, TYPE_BIT, ENDP_LSB)
  - the entry-width function
- One sub-module, usbt_pkt_fifo_mem: a DEPTH x ENTRY_WIDTH register array with one write port and one combinational read port. It is swappable for a BIST-wrapped RAM.

## Test plan
- AWIDTH=3; write 3-entry packet (eop on 3rd) -> read_ready stays 0 until the cycle after 3rd write, then read_used=3, read_data matches entries in order.
- Fill 7 of 8 entries committed, start 2-entry packet -> 2nd write dropped, wr_ptr rolls back to 7, fifo_full=1, drop_cnt=1 on eop, state HOLD.
- HOLD with th=4: pop until free=4 while no packet is in flight -> ACCEPT next cycle. A packet in flight at that moment delays ACCEPT until its eop.
- Simultaneous read and write while full (used_all=8) -> write dropped, pop succeeds, read_used=7.
- drop_cnt at 255 plus another drop -> stays 255. drop_cnt_clr and drop in same cycle -> 0. fifo_max_indication_clr while read_used=5 -> 5.
- Assert reset_n low mid-packet with 4 committed entries -> all outputs return to reset values next edge; a new packet is then accepted normally.
